gpu_raster_core: RTL and testbench
==================================

Name: gpu_raster_core

Overview:
- Small fixed-function 3D rasteriser.
- Vertex words are loaded into an internal RAM through a simple write port. A start pulse makes the block transform every vertex by a 4x4 fixed-point matrix and project it orthographically onto an 800x600 screen.
- Each triangle is rasterised by scanning its clipped bounding box and emitting one pixel per clock to an external framebuffer writer.
- frame_end pulses once all triangles are done.

Parameters:
- M, 11, integer bits of signed fixed-point words.
- N, 7, fractional bits (1.0 = 2^N = 128).
- VERTEX_MEM_DEPTH, 16384, vertex RAM depth in words.
- SCREEN_W, 800, screen width in pixels.
- SCREEN_H, 600, screen height in pixels.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- vertex_count  in  32  number of valid words in vertex RAM; sampled on start.
- start  in  1  one-cycle pulse that begins a frame.
- mem_wr_addr  in  log2(VERTEX_MEM_DEPTH)=14  vertex RAM write address.
- mem_wr_data  in  M+N=18  signed vertex word (QM.N).
- mem_wr_en  in  1  vertex RAM write enable.
- transform_matrix  in  16 x 18 signed (unpacked [0:15])  row-major 4x4 matrix, QM.N.
- output_color  out  8  pixel colour.
- output_valid  out  1  pixel_x_out, pixel_y_out, draw and output_color are valid this cycle.
- pixel_x_out  out  11  screen x, 0..799.
- pixel_y_out  out  11  screen y, 0..599.
- frame_end  out  1  one-cycle pulse at end of frame.
- draw  out  1  pixel lies inside the current triangle.

Behaviour:
- Reset: all outputs are 0; FSM goes to IDLE. RAM contents are not cleared.
- RAM write: on a clk edge with mem_wr_en=1, RAM[mem_wr_addr] <= mem_wr_data. Writes are accepted in any state; the result is undefined for data being read during a frame. The address is unsigned, so addr 16383 is a legal write.
- Vertex layout: consecutive words x, y, z. Each triangle is 9 words. Triangle count T = floor(vertex_count/9); leftover words are ignored.
- FSM: IDLE -> (start) FETCH -> XFORM -> SETUP -> SCAN -> next triangle FETCH, or DONE after the last triangle -> IDLE.
  - start is ignored outside IDLE.
  - T=0: DONE is reached directly, frame_end pulses with no pixels output.
- Transform per vertex, with the matrix taken as rows m[4r+c] and w=1.0:
  - t_r = (m[4r]*x + m[4r+1]*y + m[4r+2]*z + m[4r+3]*128) >>> N.
  - Accumulate in at least 2(M+N)+2 = 38 bits; the shift is arithmetic.
  - Only rows 0 and 1 are used; z only affects the products.
- Projection:
  - sx = SCREEN_W/2 + (t0 >>> N).
  - sy = SCREEN_H/2 - (t1 >>> N).
  - Both are signed 13-bit.
- Bounding box:
  - min/max of the three sx and the three sy, clamped to [0,SCREEN_W-1] and [0,SCREEN_H-1].
  - If the box is fully off-screen (max < 0 or min > limit), the triangle emits nothing.
- Scan order: y from ymin to ymax (outer loop), x from xmin to xmax (inner loop). One pixel per clock with output_valid=1; no backpressure.
- Inside test, with E_ab(p) = (bx-ax)(py-ay) - (by-ay)(px-ax):
  - draw = 1 when E01, E12 and E20 are all >= 0, or all <= 0, so both windings are accepted.
  - Edges and vertices count as inside.
  - A degenerate triangle (all E = 0) draws every box pixel that lies on its line.
- Colour: output_color = (triangle_index + 1) mod 256, with the first triangle at index 0.
- frame_end: asserts 1 cycle after the last output_valid of the frame, for exactly 1 cycle. output_valid is 0 that cycle.
- Latency: first output_valid occurs at most 32 cycles after start, given T >= 1 and an on-screen triangle.
- Reset during a frame aborts it: no frame_end; outputs go to 0 on the next edge.

Test Plan:
- Identity matrix (128 on the diagonal, others 0); one triangle (0,0,0),(1280,0,0),(0,1280,0) -> screen vertices (400,300),(410,300),(400,290).
  - 121 output_valid cycles, 66 with draw=1, colour 1, then a single frame_end.
- Same setup: first pixel (400,290) has draw=1; pixel (410,290) has draw=0; last pixel (410,300) has draw=1.
- vertex_count=0 or 8, then start -> no output_valid; frame_end pulses once.
- Two triangles (vertex_count=18) -> pixels of triangle 0 all carry colour 1 and are emitted before triangle 1's, which carry colour 2. A second start pulse during the scan has no effect.
- Triangle with x up to 100000 (Q11.7 = 781 px) -> pixel_x_out never exceeds 799 and the box is clamped; a triangle fully left of the screen emits 0 pixels.
- Reset asserted mid-SCAN -> the next cycle has output_valid=0 and frame_end=0. A new start renders the full frame correctly, with RAM contents retained.

Source files
------------

// File: rtl/gpu_raster_core.sv
//==============================================================================
// Module   : gpu_raster_core
// Brief    : Fixed-function triangle rasteriser. Vertices are fetched from an
//            internal RAM, transformed by a 4x4 fixed-point matrix, projected
//            onto the screen and scanned over their clipped bounding box.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module gpu_raster_core #(
    parameter int M                = 11,
    parameter int N                = 7,
    parameter int VERTEX_MEM_DEPTH = 16384,
    parameter int SCREEN_W         = 800,
    parameter int SCREEN_H         = 600
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [31:0]                         vertex_count,
    input  logic                                start,
    input  logic [$clog2(VERTEX_MEM_DEPTH)-1:0] mem_wr_addr,
    input  logic signed [M+N-1:0]               mem_wr_data,
    input  logic                                mem_wr_en,
    input  logic signed [M+N-1:0]               transform_matrix [0:15],
    output logic [7:0]                          output_color,
    output logic                                output_valid,
    output logic [10:0]                         pixel_x_out,
    output logic [10:0]                         pixel_y_out,
    output logic                                frame_end,
    output logic                                draw
);

    localparam int c_W     = M + N;
    localparam int c_ACC_W = 2 * c_W + 2;
    localparam int c_AW    = $clog2(VERTEX_MEM_DEPTH);

    localparam logic signed [c_ACC_W-1:0] c_ONE  = c_ACC_W'(1 << N);
    localparam logic signed [12:0]        c_XLIM = 13'(SCREEN_W - 1);
    localparam logic signed [12:0]        c_YLIM = 13'(SCREEN_H - 1);
    localparam logic signed [12:0]        c_XC   = 13'(SCREEN_W / 2);
    localparam logic signed [12:0]        c_YC   = 13'(SCREEN_H / 2);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_XFORM = 3'd2;
    localparam logic [2:0] c_SETUP = 3'd3;
    localparam logic [2:0] c_SCAN  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    // Sign-extend a vertex/matrix word to accumulator width
    function automatic logic signed [c_ACC_W-1:0] f_sext(input logic signed [c_W-1:0] v);
        return c_ACC_W'(v);
    endfunction

    // Edge function E_ab(p) = (bx-ax)(py-ay) - (by-ay)(px-ax)
    function automatic logic signed [29:0] f_edge(
        input logic signed [12:0] ax, input logic signed [12:0] ay,
        input logic signed [12:0] bx, input logic signed [12:0] by,
        input logic signed [12:0] px, input logic signed [12:0] py);
        logic signed [29:0] dx, dy, qx, qy;
        dx = 30'(bx) - 30'(ax);
        dy = 30'(by) - 30'(ay);
        qx = 30'(px) - 30'(ax);
        qy = 30'(py) - 30'(ay);
        return dx * qy - dy * qx;
    endfunction

    logic [2:0]               r_state, w_next;
    logic signed [c_W-1:0]    r_mem [0:VERTEX_MEM_DEPTH-1];
    logic signed [c_W-1:0]    r_rdata;
    logic signed [c_W-1:0]    r_vtx [0:8];
    logic signed [12:0]       r_sx [0:2];
    logic signed [12:0]       r_sy [0:2];
    logic [3:0]               r_fcnt;
    logic [1:0]               r_vi;
    logic [31:0]              r_base, r_vcount;
    logic [7:0]               r_tri;
    logic [10:0]              r_px, r_py, r_xmin, r_xmax, r_ymin, r_ymax;
    logic                     r_o_valid, r_o_draw, r_o_fe;
    logic [7:0]               r_o_color;
    logic [10:0]              r_o_x, r_o_y;

    logic [c_AW-1:0]          w_rd_addr;
    logic signed [c_W-1:0]    w_vx, w_vy, w_vz;
    logic signed [c_ACC_W-1:0] w_acc0, w_acc1, w_sh0, w_sh1;
    logic signed [12:0]       w_sx, w_sy;
    logic signed [12:0]       w_xmin, w_xmax, w_ymin, w_ymax;
    logic [10:0]              w_cxmin, w_cxmax, w_cymin, w_cymax;
    logic                     w_off, w_more, w_last_x, w_last_y, w_inside;
    logic signed [12:0]       w_pxs, w_pys;
    logic signed [29:0]       w_e01, w_e12, w_e20;
    logic                     w_valid, w_draw, w_fe;
    logic [7:0]               w_color;
    logic [10:0]              w_ox, w_oy;

    assign w_rd_addr = r_base[c_AW-1:0] + c_AW'(r_fcnt);

    // Vertex RAM: write port from the host, registered read for the fetcher
    always_ff @(posedge clk) begin
        if (mem_wr_en) r_mem[mem_wr_addr] <= mem_wr_data;
        r_rdata <= r_mem[w_rd_addr];
    end

    // Pick the x/y/z words of the vertex being transformed
    always_comb begin
        w_vx = r_vtx[0]; w_vy = r_vtx[1]; w_vz = r_vtx[2];
        case (r_vi)
            2'd1:    begin w_vx = r_vtx[3]; w_vy = r_vtx[4]; w_vz = r_vtx[5]; end
            2'd2:    begin w_vx = r_vtx[6]; w_vy = r_vtx[7]; w_vz = r_vtx[8]; end
            default: ;
        endcase
    end

    // Rows 0 and 1 of the matrix with w = 1.0, then projection to screen space
    assign w_acc0 = f_sext(transform_matrix[0]) * f_sext(w_vx) + f_sext(transform_matrix[1]) * f_sext(w_vy)
                  + f_sext(transform_matrix[2]) * f_sext(w_vz) + f_sext(transform_matrix[3]) * c_ONE;
    assign w_acc1 = f_sext(transform_matrix[4]) * f_sext(w_vx) + f_sext(transform_matrix[5]) * f_sext(w_vy)
                  + f_sext(transform_matrix[6]) * f_sext(w_vz) + f_sext(transform_matrix[7]) * c_ONE;
    // Two arithmetic shifts by N compose into one shift by 2N
    assign w_sh0  = w_acc0 >>> (2 * N);
    assign w_sh1  = w_acc1 >>> (2 * N);
    assign w_sx   = c_XC + w_sh0[12:0];
    assign w_sy   = c_YC - w_sh1[12:0];

    // Bounding box, off-screen rejection and clamping
    always_comb begin
        w_xmin = (r_sx[0] < r_sx[1]) ? r_sx[0] : r_sx[1];
        w_xmin = (r_sx[2] < w_xmin)  ? r_sx[2] : w_xmin;
        w_xmax = (r_sx[0] > r_sx[1]) ? r_sx[0] : r_sx[1];
        w_xmax = (r_sx[2] > w_xmax)  ? r_sx[2] : w_xmax;
        w_ymin = (r_sy[0] < r_sy[1]) ? r_sy[0] : r_sy[1];
        w_ymin = (r_sy[2] < w_ymin)  ? r_sy[2] : w_ymin;
        w_ymax = (r_sy[0] > r_sy[1]) ? r_sy[0] : r_sy[1];
        w_ymax = (r_sy[2] > w_ymax)  ? r_sy[2] : w_ymax;
        w_off  = (w_xmax < 13'sd0) || (w_xmin > c_XLIM) || (w_ymax < 13'sd0) || (w_ymin > c_YLIM);
        w_cxmin = (w_xmin < 13'sd0) ? 11'd0 : w_xmin[10:0];
        w_cymin = (w_ymin < 13'sd0) ? 11'd0 : w_ymin[10:0];
        w_cxmax = (w_xmax > c_XLIM) ? c_XLIM[10:0] : w_xmax[10:0];
        w_cymax = (w_ymax > c_YLIM) ? c_YLIM[10:0] : w_ymax[10:0];
    end

    // Inside test accepts both windings; edges and vertices count as inside
    assign w_pxs    = {2'b00, r_px};
    assign w_pys    = {2'b00, r_py};
    assign w_e01    = f_edge(r_sx[0], r_sy[0], r_sx[1], r_sy[1], w_pxs, w_pys);
    assign w_e12    = f_edge(r_sx[1], r_sy[1], r_sx[2], r_sy[2], w_pxs, w_pys);
    assign w_e20    = f_edge(r_sx[2], r_sy[2], r_sx[0], r_sy[0], w_pxs, w_pys);
    assign w_inside = ((w_e01 >= 0) && (w_e12 >= 0) && (w_e20 >= 0)) ||
                      ((w_e01 <= 0) && (w_e12 <= 0) && (w_e20 <= 0));

    assign w_last_x = (r_px == r_xmax);
    assign w_last_y = (r_py == r_ymax);
    assign w_more   = ({1'b0, r_base} + 33'd18) <= {1'b0, r_vcount};

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next = (vertex_count >= 32'd9) ? c_FETCH : c_DONE;
            c_FETCH: if (r_fcnt == 4'd9) w_next = c_XFORM;
            c_XFORM: if (r_vi == 2'd2) w_next = c_SETUP;
            c_SETUP: if (w_off) w_next = w_more ? c_FETCH : c_DONE;
                     else       w_next = c_SCAN;
            c_SCAN:  if (w_last_x && w_last_y) w_next = w_more ? c_FETCH : c_DONE;
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Output decode, registered below so outputs clear on the reset edge
    always_comb begin
        w_valid = (r_state == c_SCAN);
        w_draw  = w_valid && w_inside;
        w_color = w_valid ? (r_tri + 8'd1) : 8'd0;
        w_ox    = w_valid ? r_px : 11'd0;
        w_oy    = w_valid ? r_py : 11'd0;
        w_fe    = (r_state == c_DONE);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_o_valid <= 1'b0; r_o_draw <= 1'b0; r_o_fe <= 1'b0;
            r_o_color <= 8'd0; r_o_x <= 11'd0; r_o_y <= 11'd0;
        end else begin
            r_o_valid <= w_valid; r_o_draw <= w_draw; r_o_fe <= w_fe;
            r_o_color <= w_color; r_o_x <= w_ox; r_o_y <= w_oy;
        end
    end

    // Datapath: fetch counter, vertex transform results, box and scan position
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fcnt <= 4'd0; r_vi <= 2'd0; r_base <= 32'd0; r_vcount <= 32'd0; r_tri <= 8'd0;
            r_px <= 11'd0; r_py <= 11'd0;
            r_xmin <= 11'd0; r_xmax <= 11'd0; r_ymin <= 11'd0; r_ymax <= 11'd0;
            for (int i = 0; i < 9; i++) r_vtx[i] <= '0;
            for (int i = 0; i < 3; i++) begin r_sx[i] <= '0; r_sy[i] <= '0; end
        end else begin
            r_fcnt <= 4'd0;
            r_vi   <= 2'd0;
            case (r_state)
                c_IDLE: if (start) begin
                    r_vcount <= vertex_count;
                    r_base   <= 32'd0;
                    r_tri    <= 8'd0;
                end
                c_FETCH: begin
                    // Read data lags the address by one cycle
                    r_fcnt <= r_fcnt + 4'd1;
                    if (r_fcnt != 4'd0) r_vtx[r_fcnt - 4'd1] <= r_rdata;
                end
                c_XFORM: begin
                    r_vi       <= r_vi + 2'd1;
                    r_sx[r_vi] <= w_sx;
                    r_sy[r_vi] <= w_sy;
                end
                c_SETUP: begin
                    r_xmin <= w_cxmin; r_xmax <= w_cxmax;
                    r_ymin <= w_cymin; r_ymax <= w_cymax;
                    r_px   <= w_cxmin; r_py   <= w_cymin;
                    if (w_off) begin
                        r_base <= r_base + 32'd9;
                        r_tri  <= r_tri + 8'd1;
                    end
                end
                c_SCAN: begin
                    if (w_last_x) begin
                        r_px <= r_xmin;
                        if (w_last_y) begin
                            r_base <= r_base + 32'd9;
                            r_tri  <= r_tri + 8'd1;
                        end else begin
                            r_py <= r_py + 11'd1;
                        end
                    end else begin
                        r_px <= r_px + 11'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign output_valid = r_o_valid;
    assign draw         = r_o_draw;
    assign frame_end    = r_o_fe;
    assign output_color = r_o_color;
    assign pixel_x_out  = r_o_x;
    assign pixel_y_out  = r_o_y;

endmodule

`default_nettype wire

// File: tb/tb_gpu_raster_core.sv
//==============================================================================
// Module   : tb_gpu_raster_core
// Brief    : Self-checking bench for gpu_raster_core using a table of directed
//            frames plus hand-written first/last pixel, restart and reset cases.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_gpu_raster_core;

    logic               clk = 1'b0;
    logic               reset;
    logic [31:0]        vertex_count;
    logic               start;
    logic [13:0]        mem_wr_addr;
    logic signed [17:0] mem_wr_data;
    logic               mem_wr_en;
    logic signed [17:0] mat [0:15];
    logic [7:0]         output_color;
    logic               output_valid;
    logic [10:0]        pixel_x_out;
    logic [10:0]        pixel_y_out;
    logic               frame_end;
    logic               draw;

    gpu_raster_core dut (
        .clk              (clk),
        .reset            (reset),
        .vertex_count     (vertex_count),
        .start            (start),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data),
        .mem_wr_en        (mem_wr_en),
        .transform_matrix (mat),
        .output_color     (output_color),
        .output_valid     (output_valid),
        .pixel_x_out      (pixel_x_out),
        .pixel_y_out      (pixel_y_out),
        .frame_end        (frame_end),
        .draw             (draw)
    );

    always #5 clk = ~clk;

    typedef struct {
        int vc;        // vertex_count
        int t0;        // shape at words 0..8
        int t1;        // shape at words 9..17 (-1 = none)
        int tx;        // matrix[3] translation term
        bit restart;   // extra start pulse mid-scan
        int e_valid;
        int e_draw;
        int e_c1;
        int e_c2;
        int e_maxx;
    } vec_t;

    int shp [5][9];
    vec_t vecs [9];

    int n_checks = 0;
    int n_fail   = 0;

    // frame statistics
    int n_valid, n_draw, n_c1, n_c2, n_fe, n_order, maxx, lat;
    int first_x, first_y, first_d, last_x, last_y, last_d, cap_d;
    bit timed_out;
    longint last_key;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr_word(input int addr, input int val);
        mem_wr_en   = 1'b1;
        mem_wr_addr = 14'(addr);
        mem_wr_data = 18'(val);
        @(negedge clk);
        mem_wr_en   = 1'b0;
    endtask

    task automatic load_shape(input int base, input int s);
        for (int i = 0; i < 9; i++) wr_word(base + i, shp[s][i]);
    endtask

    task automatic set_matrix(input int tx);
        for (int i = 0; i < 16; i++) mat[i] = 18'sd0;
        mat[0] = 18'sd128; mat[5] = 18'sd128; mat[10] = 18'sd128; mat[15] = 18'sd128;
        mat[3] = 18'(tx);
    endtask

    // Sample one cycle of DUT outputs into the frame statistics
    task automatic sample(input int cyc);
        longint key;
        if (output_valid) begin
            n_valid++;
            if (draw) n_draw++;
            if (output_color == 8'd1) n_c1++;
            if (output_color == 8'd2) n_c2++;
            if (int'(pixel_x_out) > maxx) maxx = int'(pixel_x_out);
            if (lat < 0) begin
                lat = cyc; first_x = int'(pixel_x_out); first_y = int'(pixel_y_out); first_d = int'(draw);
            end
            last_x = int'(pixel_x_out); last_y = int'(pixel_y_out); last_d = int'(draw);
            if (pixel_x_out == 11'd410 && pixel_y_out == 11'd290) cap_d = int'(draw);
            key = (longint'(output_color) << 24) + (longint'(pixel_y_out) << 12) + longint'(pixel_x_out);
            if (key <= last_key) n_order++;
            last_key = key;
        end
        if (frame_end) begin
            n_fe++;
            if (output_valid) n_order++;
        end
    endtask

    task automatic run_frame(input int vc, input bit restart);
        int cyc, post;
        bit seen;
        n_valid = 0; n_draw = 0; n_c1 = 0; n_c2 = 0; n_fe = 0; n_order = 0;
        maxx = -1; lat = -1; cap_d = -1; last_key = -1;
        first_x = -1; first_y = -1; first_d = -1; last_x = -1; last_y = -1; last_d = -1;
        vertex_count = 32'(vc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; post = 0; seen = 1'b0;
        while (cyc < 10000 && post < 6) begin
            sample(cyc);
            if (frame_end) seen = 1'b1;
            if (seen) post++;
            start = restart && (cyc == 40);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        timed_out = !seen;
    endtask

    initial begin
        shp = '{'{0, 0, 0,       1280, 0, 0,    0, 1280, 0},
                '{0, 0, 0,       100000, 0, 0,  0, 1280, 0},
                '{-100000, 0, 0, -99000, 0, 0,  -100000, 1280, 0},
                '{0, 0, 0,       640, 0, 0,     1280, 0, 0},
                '{0, 0, 300,     256, 0, 300,   0, 256, 300}};
        //          vc  t0 t1  tx    rs  valid draw  c1   c2   maxx
        vecs[0] = '{9,  0, -1, 0,    0,  121,  66,  121, 0,   410};
        vecs[1] = '{0,  0, -1, 0,    0,  0,    0,   0,   0,   -1};
        vecs[2] = '{8,  0, -1, 0,    0,  0,    0,   0,   0,   -1};
        vecs[3] = '{18, 0, 4,  0,    1,  130,  72,  121, 9,   410};
        vecs[4] = '{9,  1, -1, 0,    0,  4400, 3176, 4400, 0, 799};
        vecs[5] = '{9,  2, -1, 0,    0,  0,    0,   0,   0,   -1};
        vecs[6] = '{17, 3, 4,  0,    0,  11,   11,  11,  0,   410};
        vecs[7] = '{18, 2, 0,  0,    0,  121,  66,  0,   121, 410};
        vecs[8] = '{9,  4, -1, 1280, 0,  9,    6,   9,   0,   412};

        reset = 1'b1; start = 1'b0; vertex_count = 32'd0;
        mem_wr_addr = 14'd0; mem_wr_data = 18'sd0; mem_wr_en = 1'b0;
        set_matrix(0);
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(output_valid), 0);
        chk("reset_frame_end", int'(frame_end), 0);
        chk("reset_draw", int'(draw), 0);
        chk("reset_color", int'(output_color), 0);
        chk("reset_x", int'(pixel_x_out), 0);
        chk("reset_y", int'(pixel_y_out), 0);
        reset = 1'b0;
        @(negedge clk);

        // Top address is a legal write target
        wr_word(16383, 12345);

        // Single reference triangle: corner pixels and latency
        load_shape(0, 0);
        run_frame(9, 1'b0);
        chk("ref_timeout", int'(timed_out), 0);
        chk("ref_first_x", first_x, 400);
        chk("ref_first_y", first_y, 290);
        chk("ref_first_draw", first_d, 1);
        chk("ref_410_290_draw", cap_d, 0);
        chk("ref_last_x", last_x, 410);
        chk("ref_last_y", last_y, 300);
        chk("ref_last_draw", last_d, 1);
        chk("ref_latency_le32", int'(lat >= 0 && lat <= 32), 1);

        // Table of directed frames
        for (int v = 0; v < 9; v++) begin
            set_matrix(vecs[v].tx);
            load_shape(0, vecs[v].t0);
            if (vecs[v].t1 >= 0) load_shape(9, vecs[v].t1);
            run_frame(vecs[v].vc, vecs[v].restart);
            chk($sformatf("v%0d_timeout", v), int'(timed_out), 0);
            chk($sformatf("v%0d_valid", v), n_valid, vecs[v].e_valid);
            chk($sformatf("v%0d_draw", v), n_draw, vecs[v].e_draw);
            chk($sformatf("v%0d_color1", v), n_c1, vecs[v].e_c1);
            chk($sformatf("v%0d_color2", v), n_c2, vecs[v].e_c2);
            chk($sformatf("v%0d_frame_end", v), n_fe, 1);
            chk($sformatf("v%0d_maxx", v), maxx, vecs[v].e_maxx);
            chk($sformatf("v%0d_order", v), n_order, 0);
        end

        // Reset in the middle of a scan, then a fresh frame from retained RAM
        set_matrix(0);
        load_shape(0, 0);
        vertex_count = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int guard = 0;
            while (!output_valid && guard < 100) begin @(negedge clk); guard++; end
            chk("rst_scan_reached", int'(output_valid), 1);
        end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valid_cleared", int'(output_valid), 0);
        chk("rst_frame_end", int'(frame_end), 0);
        chk("rst_draw_cleared", int'(draw), 0);
        chk("rst_x_cleared", int'(pixel_x_out), 0);
        reset = 1'b0;
        begin
            int fe_cnt = 0;
            int vcnt = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (frame_end) fe_cnt++;
                if (output_valid) vcnt++;
            end
            chk("rst_no_frame_end", fe_cnt, 0);
            chk("rst_no_valid", vcnt, 0);
        end
        run_frame(9, 1'b0);
        chk("rerun_timeout", int'(timed_out), 0);
        chk("rerun_valid", n_valid, 121);
        chk("rerun_draw", n_draw, 66);
        chk("rerun_color1", n_c1, 121);
        chk("rerun_frame_end", n_fe, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
